// File: rtl/pitch_detector_pkg.sv
// Shared constants and types for the pitch detector and the downstream FIFO/compare/tally stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pitch_detector_pkg;

  localparam int FREQ_W       = 15;
  localparam int FREQ_MAX     = 32767;
  localparam int DEF_FS_HZ    = 48000;
  localparam int DEF_SAMPLE_W = 16;

  // Wide enough for a sample index, a saturating crossing count (up to 32768)
  // and the 16-bit divider denominator.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_WRITE
  } state_t;

  // POS doubles as the unarmed state: a crossing needs a visit to NEG first.
  typedef enum logic {
    REG_POS,
    REG_NEG
  } region_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] first_idx;
    logic [CNT_W-1:0] last_idx;
  } snap_t;

  function automatic logic [FREQ_W-1:0] clamp_freq(input logic [31:0] q);
    if (q > 32'(FREQ_MAX)) return FREQ_W'(FREQ_MAX);
    return q[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/pitch_detector_if.sv
// Sample stream in, frequency words out to the song FIFO.
// Latency: n/a (wiring only).
// Backpressure: fifo_full holds the write; the sample stream itself is never stalled.
// Ports: sample_valid/sample (audio in), fifo_full (FIFO status),
//        freq_dout/freq_wr_en (FIFO write), frame_dropped/busy (status).
interface pitch_detector_if
  import pitch_detector_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       fifo_full;
  logic [FREQ_W-1:0]          freq_dout;
  logic                       freq_wr_en;
  logic                       frame_dropped;
  logic                       busy;

  modport master (
    output sample_valid, sample, fifo_full,
    input  freq_dout, freq_wr_en, frame_dropped, busy
  );

  modport slave (
    input  sample_valid, sample, fifo_full,
    output freq_dout, freq_wr_en, frame_dropped, busy
  );
endinterface

// File: rtl/pitch_detector_serial_divider.sv
// Restoring unsigned divider, 32-bit numerator by 16-bit denominator, truncating.
// Latency: fixed 32 cycles; done is high in the 32nd cycle after the start edge.
// Backpressure: none; start is only honoured by the caller when idle.
// Ports: clk, rst (async, active high), start, numer[31:0], denom[15:0], done, quotient[31:0].
module serial_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] numer,
  input  logic [15:0] denom,
  output logic        done,
  output logic [31:0] quotient
);

  logic [15:0] rem;
  logic [31:0] quo;
  logic [15:0] den;
  logic [5:0]  steps;
  logic        running;

  logic [15:0] rem_in;
  logic [31:0] quo_in;
  logic [15:0] den_in;
  logic [16:0] rem_sh;
  logic        q_bit;
  logic [15:0] rem_nxt;
  logic [31:0] quo_nxt;

  // The first quotient bit is produced on the start edge itself, so 32 bits
  // are complete one cycle after the 31st running edge.
  always_comb begin
    rem_in  = start ? 16'd0 : rem;
    quo_in  = start ? numer : quo;
    den_in  = start ? denom : den;
    rem_sh  = {rem_in, quo_in[31]};
    q_bit   = (rem_sh >= {1'b0, den_in});
    // Remainder stays below the denominator, so 16 bits always hold it.
    rem_nxt = q_bit ? 16'(rem_sh - {1'b0, den_in}) : rem_sh[15:0];
    quo_nxt = {quo_in[30:0], q_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem     <= '0;
      quo     <= '0;
      den     <= '0;
      steps   <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= rem_nxt;
      quo     <= quo_nxt;
      den     <= denom;
      steps   <= 6'd1;
      running <= 1'b1;
    end else if (running) begin
      if (steps == 6'd32) begin
        running <= 1'b0;
      end else begin
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        steps <= steps + 6'd1;
      end
    end
  end

  assign done     = running && (steps == 6'd32);
  assign quotient = quo;

endmodule

// File: rtl/pitch_detector.sv
// Per-frame pitch estimate: counts hysteresis rising crossings, divides FS*(C-1) by their span.
// Latency: write 33 cycles after the frame-end sample (1 cycle when fewer than 2 crossings).
// Backpressure: write waits while fifo_full; a frame ending meanwhile is dropped, never stalls input.
// Ports: clk, rst (async, active high), bus (slave: sample_valid/sample/fifo_full in,
//        freq_dout/freq_wr_en/frame_dropped/busy out).
module pitch_detector
  import pitch_detector_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int FS_HZ     = DEF_FS_HZ,
  parameter int FRAME_LEN = 2048,
  parameter int HYST      = 256
) (
  input  logic             clk,
  input  logic             rst,
  pitch_detector_if.slave  bus
);

  localparam logic signed [SAMPLE_W-1:0] POS_TH   = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] NEG_TH   = SAMPLE_W'(-HYST);
  localparam logic [CNT_W-1:0]           LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]           CNT_SAT  = CNT_W'(FRAME_LEN);
  localparam logic [31:0]                FS_W     = 32'(FS_HZ);

  // Collection side
  region_t          region;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] first_idx;
  logic [CNT_W-1:0] last_idx;
  logic             crossing;
  logic             frame_end;
  snap_t            snap;

  // Output side
  state_t            state, state_nxt;
  logic [FREQ_W-1:0] result, result_nxt;
  logic              drop_q, drop_nxt;
  logic              wr_en;
  logic              div_start;
  logic              div_done;
  logic [31:0]       div_num;
  logic [15:0]       div_den;
  logic [31:0]       div_quot;

  // The snapshot includes the frame-end sample's own crossing, so it is
  // formed from the next-state values rather than the registers.
  always_comb begin
    crossing       = bus.sample_valid && (region == REG_NEG) && (bus.sample >= POS_TH);
    snap.cnt       = cnt;
    snap.first_idx = first_idx;
    snap.last_idx  = last_idx;
    if (crossing) begin
      if (cnt != CNT_SAT) snap.cnt = cnt + 16'd1;
      if (cnt == '0) snap.first_idx = idx;
      snap.last_idx = idx;
    end
    frame_end = bus.sample_valid && (idx == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      region    <= REG_POS;
      idx       <= '0;
      cnt       <= '0;
      first_idx <= '0;
      last_idx  <= '0;
    end else if (bus.sample_valid) begin
      if (bus.sample <= NEG_TH) begin
        region <= REG_NEG;
      end else if (bus.sample >= POS_TH) begin
        region <= REG_POS;
      end
      // Region deliberately survives the frame boundary.
      if (frame_end) begin
        idx       <= '0;
        cnt       <= '0;
        first_idx <= '0;
        last_idx  <= '0;
      end else begin
        idx       <= idx + 16'd1;
        cnt       <= snap.cnt;
        first_idx <= snap.first_idx;
        last_idx  <= snap.last_idx;
      end
    end
  end

  assign div_num = FS_W * (32'(snap.cnt) - 32'd1);
  assign div_den = snap.last_idx - snap.first_idx;

  serial_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .numer    (div_num),
    .denom    (div_den),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    div_start  = 1'b0;
    wr_en      = 1'b0;
    drop_nxt   = frame_end && (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (frame_end) begin
          if (snap.cnt < 16'd2) begin
            result_nxt = '0;
            state_nxt  = ST_WRITE;
          end else begin
            div_start  = 1'b1;
            state_nxt  = ST_DIVIDE;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          result_nxt = clamp_freq(div_quot);
          state_nxt  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!bus.fifo_full) begin
          wr_en     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      result <= '0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      result <= result_nxt;
      drop_q <= drop_nxt;
    end
  end

  assign bus.freq_dout     = result;
  assign bus.freq_wr_en    = wr_en;
  assign bus.frame_dropped = drop_q;
  assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_pitch_detector.sv
module tb_pitch_detector;
  import pitch_detector_pkg::*;

  localparam int FL = 2048;
  localparam int FS = 48000;
  localparam int HY = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pitch_detector_if #(.SAMPLE_W(16)) bus ();
  pitch_detector_if #(.SAMPLE_W(16)) bus2 ();

  pitch_detector #(.SAMPLE_W(16), .FS_HZ(FS), .FRAME_LEN(FL), .HYST(HY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pitch_detector #(.SAMPLE_W(16), .FS_HZ(96000), .FRAME_LEN(64), .HYST(HY)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } wr_t;

  wr_t wr_log[$];
  wr_t wr2_log[$];
  int  drop_log[$];
  int  fe_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frequency of one frame from its rising-crossing indices.
  function automatic int frame_freq(input int fs, input int xs[$]);
    longint q;
    if (xs.size() < 2) return 0;
    q = (longint'(fs) * longint'(xs.size() - 1)) / longint'(xs[xs.size()-1] - xs[0]);
    return (q > 32767) ? 32767 : int'(q);
  endfunction

  // Behavioural model: frame bookkeeping plus one pending result with a
  // known earliest write cycle.
  int  m_idx   = 0;
  bit  m_neg   = 1'b0;
  int  m_xs[$];
  bit  m_pend  = 1'b0;
  int  m_start = 0;
  int  m_ready = 0;
  int  m_val   = 0;
  bit  m_drop  = 1'b0;

  always @(negedge clk) begin : cmp
    bit  b_exp;
    bit  w_exp;
    int  s;
    wr_t w;
    if (rst) begin
      check("rst_freq_dout", bus.freq_dout, 0);
      check("rst_wr_en", bus.freq_wr_en, 0);
      check("rst_dropped", bus.frame_dropped, 0);
      check("rst_busy", bus.busy, 0);
      m_idx = 0; m_neg = 1'b0; m_xs.delete(); m_pend = 1'b0; m_drop = 1'b0;
    end else begin
      b_exp = m_pend && (cyc >= m_start);
      w_exp = b_exp && (cyc >= m_ready) && !bus.fifo_full;
      check("busy", bus.busy, b_exp);
      check("wr_en", bus.freq_wr_en, w_exp);
      check("frame_dropped", bus.frame_dropped, m_drop);
      if (w_exp) begin
        check("freq_dout", bus.freq_dout, m_val);
        m_pend = 1'b0;
      end
      if (bus.freq_wr_en) begin
        w.val = int'(bus.freq_dout);
        w.cyc = cyc;
        wr_log.push_back(w);
      end
      if (bus.frame_dropped) drop_log.push_back(cyc);
      m_drop = 1'b0;
      if (bus.sample_valid) begin
        s = bus.sample;
        if (s <= -HY) begin
          m_neg = 1'b1;
        end else if (s >= HY) begin
          if (m_neg) m_xs.push_back(m_idx);
          m_neg = 1'b0;
        end
        if (m_idx == FL - 1) begin
          fe_log.push_back(cyc);
          if (b_exp) begin
            m_drop = 1'b1;
          end else begin
            m_pend  = 1'b1;
            m_val   = frame_freq(FS, m_xs);
            m_start = cyc + 1;
            m_ready = cyc + ((m_xs.size() >= 2) ? 33 : 1);
          end
          m_xs.delete();
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  always @(negedge clk) begin : mon2
    wr_t w;
    if (!rst && bus2.freq_wr_en) begin
      w.val = int'(bus2.freq_dout);
      w.cyc = cyc;
      wr2_log.push_back(w);
    end
  end

  task automatic send(input int s);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample       = 16'(s);
  endtask

  task automatic send2(input int s);
    @(posedge clk); #1;
    bus2.sample_valid = 1'b1;
    bus2.sample       = 16'(s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.sample_valid  = 1'b0;
      bus2.sample_valid = 1'b0;
    end
  endtask

  task automatic tone(input int nsamp, input int amp, input int per);
    for (int k = 0; k < nsamp; k++) send(((k % per) < per / 2) ? amp : -amp);
  endtask

  // Checks that exactly `n` writes of `val` appeared since log index `w0`,
  // each `lat` cycles after the matching frame end from `f0`.
  task automatic expect_writes(input string name, input int w0, input int f0,
                               input int n, input int val, input int lat);
    check({name, "_count"}, wr_log.size() - w0, n);
    if (wr_log.size() == w0 + n && fe_log.size() >= f0 + n) begin
      for (int i = 0; i < n; i++) begin
        check({name, "_value"}, wr_log[w0+i].val, val);
        check({name, "_latency"}, wr_log[w0+i].cyc - fe_log[f0+i], lat);
      end
    end
  endtask

  initial begin : main
    int w0, f0, d0, rc, fe2;
    bus.sample_valid  = 1'b0;
    bus.sample        = '0;
    bus.fifo_full     = 1'b0;
    bus2.sample_valid = 1'b0;
    bus2.sample       = '0;
    bus2.fifo_full    = 1'b0;

    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_wr_en", bus.freq_wr_en, 0);
    check("reset_dout", bus.freq_dout, 0);
    check("reset_busy2", bus2.busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1 kHz square wave: three frames, each 1000 Hz after 33 cycles.
    w0 = wr_log.size(); f0 = fe_log.size();
    tone(3 * FL, 1000, 48);
    idle(40);
    expect_writes("tone1k", w0, f0, 3, 1000, 33);

    // Silence: zero result, written the cycle after each frame end.
    w0 = wr_log.size(); f0 = fe_log.size();
    for (int k = 0; k < 3 * FL; k++) send(0);
    idle(5);
    expect_writes("silence", w0, f0, 3, 0, 1);

    // Below hysteresis gives 0; period-3 tone at 300 gives 16000.
    w0 = wr_log.size(); f0 = fe_log.size();
    tone(FL, 200, 48);
    idle(3);
    expect_writes("sub_hyst", w0, f0, 1, 0, 1);
    w0 = wr_log.size(); f0 = fe_log.size();
    tone(FL, 300, 3);
    idle(40);
    expect_writes("tone16k", w0, f0, 1, 16000, 33);

    // FIFO full across two frame ends: one drop, then a single 1000 write on release.
    w0 = wr_log.size(); f0 = fe_log.size(); d0 = drop_log.size();
    bus.fifo_full = 1'b1;
    tone(2 * FL, 1000, 48);
    idle(50);
    check("full_no_write", wr_log.size() - w0, 0);
    check("full_drop_count", drop_log.size() - d0, 1);
    if (drop_log.size() == d0 + 1 && fe_log.size() == f0 + 2)
      check("full_drop_cycle", drop_log[d0] - fe_log[f0+1], 1);
    check("full_busy_held", bus.busy, 1);
    bus.fifo_full = 1'b0;
    rc = cyc;
    idle(10);
    check("release_write_count", wr_log.size() - w0, 1);
    if (wr_log.size() == w0 + 1) begin
      check("release_value", wr_log[w0].val, 1000);
      check("release_cycle", wr_log[w0].cyc - rc, 0);
    end

    // Reset in the middle of a divide: no write, then a clean frame works.
    w0 = wr_log.size(); f0 = fe_log.size();
    tone(FL, 1000, 48);
    idle(10);
    check("pre_reset_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_wr_en", bus.freq_wr_en, 0);
    check("async_rst_dout", bus.freq_dout, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(40);
    check("aborted_no_write", wr_log.size() - w0, 0);
    w0 = wr_log.size(); f0 = fe_log.size();
    tone(FL, 1000, 48);
    idle(40);
    expect_writes("post_reset", w0, f0, 1, 1000, 33);

    // 96 kHz sample rate with a period-2 tone: 48000 clamps to 32767.
    tone(0, 0, 2);
    for (int k = 0; k < 64; k++) send2((k % 2 == 0) ? 1000 : -1000);
    fe2 = cyc;
    idle(40);
    check("clamp_count", wr2_log.size(), 1);
    if (wr2_log.size() == 1) begin
      check("clamp_value", wr2_log[0].val, 32767);
      check("clamp_latency", wr2_log[0].cyc - fe2, 33);
    end
    check("clamp_busy_after", bus2.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
